axi_rd_router: RTL and testbench
================================

AXI_RD_ROUTER -- requirements
Module: axi_rd_router

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4: number of upstream AXI4 masters (2..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 2: number of downstream AXI4 slaves (1..4).
REQ-003 SHALL have parameters DATA_WIDTH 64, ADDR_WIDTH 32, ID_WIDTH 4: AXI widths; MIDX_W = $clog2(NUM_MASTERS).
REQ-004 SHALL have parameters SLAVE_BASE / SLAVE_MASK (NUM_SLAVES*ADDR_WIDTH packed), defaults {32'h8000_0000, 32'h0} / {32'h8000_0000, 32'h8000_0000}: slave k hit when (ARADDR & MASK[k]) == BASE[k].
REQ-005 SHALL have ports ACLK in 1: clock; ARESETn in 1: reset. One clock; reset is asynchronous and active-low.
REQ-006 SHALL have m_ARID/m_ARADDR/m_ARLEN/m_ARSIZE/m_ARBURST in, NUM_MASTERS x (ID_WIDTH/ADDR_WIDTH/8/3/2), packed: per-master AR payload.
REQ-007 SHALL have m_ARVALID in NUM_MASTERS and m_ARREADY out NUM_MASTERS: per-master AR handshake.
REQ-008 SHALL have m_RID out ID_WIDTH, m_RDATA out DATA_WIDTH, m_RRESP out 2, m_RLAST out 1: shared R payload.
REQ-009 SHALL have m_RVALID out NUM_MASTERS and m_RREADY in NUM_MASTERS: per-master R handshake.
REQ-010 SHALL have s_ARID out ID_WIDTH+MIDX_W, s_ARADDR/s_ARLEN/s_ARSIZE/s_ARBURST out: shared AR payload to slaves.
REQ-011 SHALL have s_ARVALID out NUM_SLAVES and s_ARREADY in NUM_SLAVES: per-slave AR handshake.
REQ-012 SHALL have s_RID/s_RDATA/s_RRESP/s_RLAST/s_RVALID in and s_RREADY out, each NUM_SLAVES wide/packed: per-slave R channel.

Function
REQ-013 SHALL be FSM IDLE, ADDR, DATA, ERR; one transaction in flight.
REQ-014 IDLE: if any m_ARVALID, SHALL grant by round-robin starting at last_grant+1, pulse m_ARREADY[g] that cycle, register AR fields, grant index g and decode result.
REQ-015 Decode: hit -> ADDR; no hit -> ERR; multiple hits -> lowest slave index wins.
REQ-016 ADDR: s_ARVALID[sel] SHALL assert the cycle after grant, hold payload stable until s_ARREADY[sel], then -> DATA.
REQ-017 s_ARID SHALL be {g, m_ARID[g]}; s_ARLEN/SIZE/BURST/ADDR passed unchanged.
REQ-018 DATA: m_R* SHALL mux combinationally from slave sel; m_RVALID[g] = s_RVALID[sel]; s_RREADY[sel] = m_RREADY[g]; m_RID = s_RID[sel][ID_WIDTH-1:0]; zero added latency.
REQ-019 DATA: R handshake with RLAST -> IDLE; last_grant <= g.
REQ-020 ERR: SHALL emit ARLEN+1 beats, RDATA 0, RRESP 2'b11 (DECERR), RID latched, RLAST on final beat; 8-bit beat counter advances only on handshake; final handshake -> IDLE, last_grant <= g.
REQ-021 All m_ARREADY, m_RVALID, s_ARVALID, s_RREADY not owned by current state SHALL be 0.
REQ-022 Next grant earliest one cycle after final RLAST handshake (IDLE dwell of 1 cycle).
REQ-023 Sustained backpressure (m_RREADY low) SHALL stall indefinitely without beat loss.

Reset
REQ-024 On ARESETn low: state IDLE, last_grant NUM_MASTERS-1 (master 0 wins first), counter 0, all valid/ready outputs 0, payload regs 0.
REQ-025 Reset mid-burst SHALL abort the transaction immediately; no beat completes after deassertion.

Structure
REQ-026 Package axi_ic_pkg SHALL hold RESP_OKAY/RESP_SLVERR/RESP_DECERR constants and rd_state_t enum.
REQ-027 Round-robin logic SHALL be sub-module rr_arbiter (param NUM_REQ; inputs req, last_grant; output one-hot grant).

Verification
REQ-028 m0 reads 0x0000_0040 ARLEN 7, slave0 returns 8 beats -> m0 gets 8 beats OKAY, RID = m0 ID, RLAST on beat 8; s_ARID = {2'd0, ID}.
REQ-029 m1 reads 0x8000_0000 ARLEN 0 -> slave1 selected, single beat RLAST=1, s_ARVALID[1] asserted cycle after m_ARREADY[1].
REQ-030 All 4 masters assert ARVALID together, ARLEN 3 each -> grant order 0,1,2,3; repeat -> 0,1,2,3.
REQ-031 NUM_SLAVES=1, BASE 0, MASK 32'h8000_0000, read 0x8000_0000 ARLEN 255 -> 256 DECERR beats, RDATA 0, RLAST on 256th, no s_ARVALID.
REQ-032 m_RREADY toggled every other cycle during 8-beat burst -> all 8 beats delivered in order, s_RREADY mirrors m_RREADY.
REQ-033 ARESETn low at beat 3 of 8 -> all valids 0 immediately; after release, master 0 granted first.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// Shared constants and state encoding for the AXI4 read interconnect blocks.
package axi_ic_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from last_grant+1 and returns a one-hot grant.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_grant,
   output logic [NUM_REQ-1:0] grant
);

   always_comb begin
      logic          found;
      logic [IW-1:0] idx;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IW'((32'(last_grant) + 32'(i)) % NUM_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_rd_router.sv
// AXI4 read-channel router: N masters to M slaves, one transaction in flight,
// round-robin grant, address decode, DECERR bursts for unmapped addresses.
module axi_rd_router
   import axi_ic_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int NUM_SLAVES  = 2,
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int ID_WIDTH    = 4,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h8000_0000, 32'h0},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'h8000_0000, 32'h8000_0000},
   localparam int MIDX_W = $clog2(NUM_MASTERS),
   localparam int SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
   localparam int SID_W  = ID_WIDTH + MIDX_W
) (
   input  logic                              ACLK,
   input  logic                              ARESETn,
   input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_ARID,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ARADDR,
   input  logic [NUM_MASTERS*8-1:0]          m_ARLEN,
   input  logic [NUM_MASTERS*3-1:0]          m_ARSIZE,
   input  logic [NUM_MASTERS*2-1:0]          m_ARBURST,
   input  logic [NUM_MASTERS-1:0]            m_ARVALID,
   output logic [NUM_MASTERS-1:0]            m_ARREADY,
   output logic [ID_WIDTH-1:0]               m_RID,
   output logic [DATA_WIDTH-1:0]             m_RDATA,
   output logic [1:0]                        m_RRESP,
   output logic                              m_RLAST,
   output logic [NUM_MASTERS-1:0]            m_RVALID,
   input  logic [NUM_MASTERS-1:0]            m_RREADY,
   output logic [SID_W-1:0]                  s_ARID,
   output logic [ADDR_WIDTH-1:0]             s_ARADDR,
   output logic [7:0]                        s_ARLEN,
   output logic [2:0]                        s_ARSIZE,
   output logic [1:0]                        s_ARBURST,
   output logic [NUM_SLAVES-1:0]             s_ARVALID,
   input  logic [NUM_SLAVES-1:0]             s_ARREADY,
   input  logic [NUM_SLAVES*SID_W-1:0]       s_RID,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_RDATA,
   input  logic [NUM_SLAVES*2-1:0]           s_RRESP,
   input  logic [NUM_SLAVES-1:0]             s_RLAST,
   input  logic [NUM_SLAVES-1:0]             s_RVALID,
   output logic [NUM_SLAVES-1:0]             s_RREADY,
   output rd_state_t                         dbg_state
);

   // Handshake rule: a beat or address transfers on a rising ACLK edge where
   // valid and ready are both high; valid never waits on ready.
   rd_state_t state, state_nxt;

   logic [NUM_MASTERS-1:0] grant_oh;
   logic [MIDX_W-1:0]      grant_idx, g_q, last_grant;
   logic [SIDX_W-1:0]      dec_sel, sel_q;
   logic                   dec_hit;
   logic [ADDR_WIDTH-1:0]  gnt_addr, addr_q;
   logic [ID_WIDTH-1:0]    id_q;
   logic [7:0]             len_q, beat_cnt;
   logic [2:0]             size_q;
   logic [1:0]             burst_q;

   logic [ID_WIDTH-1:0]    slv_rid;
   logic [DATA_WIDTH-1:0]  slv_rdata;
   logic [1:0]             slv_rresp;
   logic                   slv_rlast, slv_rvalid;
   logic                   unused_rid_hi;

   rr_arbiter #(.NUM_REQ(NUM_MASTERS)) u_arb (
      .req        (m_ARVALID),
      .last_grant (last_grant),
      .grant      (grant_oh)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (grant_oh[i]) grant_idx = MIDX_W'(i);
   end

   assign gnt_addr = m_ARADDR[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];

   // Descending scan so the lowest matching slave index is the one left standing.
   always_comb begin
      dec_hit = 1'b0;
      dec_sel = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
         if ((gnt_addr & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
             SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
            dec_hit = 1'b1;
            dec_sel = SIDX_W'(k);
         end
      end
   end

   always_comb begin
      slv_rid    = '0;
      slv_rdata  = '0;
      slv_rresp  = '0;
      slv_rlast  = 1'b0;
      slv_rvalid = 1'b0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (SIDX_W'(k) == sel_q) begin
            slv_rid    = s_RID[k*SID_W +: ID_WIDTH];
            slv_rdata  = s_RDATA[k*DATA_WIDTH +: DATA_WIDTH];
            slv_rresp  = s_RRESP[k*2 +: 2];
            slv_rlast  = s_RLAST[k];
            slv_rvalid = s_RVALID[k];
         end
      end
   end

   assign unused_rid_hi = ^s_RID;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state      <= ST_IDLE;
         last_grant <= MIDX_W'(NUM_MASTERS - 1);
         g_q        <= '0;
         sel_q      <= '0;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         beat_cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: if (|m_ARVALID) begin
               g_q     <= grant_idx;
               sel_q   <= dec_sel;
               id_q    <= m_ARID[grant_idx*ID_WIDTH +: ID_WIDTH];
               addr_q  <= gnt_addr;
               len_q   <= m_ARLEN[grant_idx*8 +: 8];
               size_q  <= m_ARSIZE[grant_idx*3 +: 3];
               burst_q <= m_ARBURST[grant_idx*2 +: 2];
            end
            ST_DATA: if (slv_rvalid && m_RREADY[g_q] && slv_rlast)
               last_grant <= g_q;
            ST_ERR: if (m_RREADY[g_q]) begin
               if (beat_cnt == len_q) begin
                  beat_cnt   <= '0;
                  last_grant <= g_q;
               end else begin
                  beat_cnt <= beat_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      m_ARREADY = '0;
      s_ARVALID = '0;
      m_RVALID  = '0;
      s_RREADY  = '0;
      m_RID     = '0;
      m_RDATA   = '0;
      m_RRESP   = RESP_OKAY;
      m_RLAST   = 1'b0;
      case (state)
         ST_IDLE: begin
            m_ARREADY = grant_oh;
            if (|m_ARVALID) state_nxt = dec_hit ? ST_ADDR : ST_ERR;
         end
         ST_ADDR: begin
            s_ARVALID[sel_q] = 1'b1;
            if (s_ARREADY[sel_q]) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            m_RID           = slv_rid;
            m_RDATA         = slv_rdata;
            m_RRESP         = slv_rresp;
            m_RLAST         = slv_rlast;
            m_RVALID[g_q]   = slv_rvalid;
            s_RREADY[sel_q] = m_RREADY[g_q];
            if (slv_rvalid && m_RREADY[g_q] && slv_rlast) state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            m_RID         = id_q;
            m_RRESP       = RESP_DECERR;
            m_RLAST       = (beat_cnt == len_q);
            m_RVALID[g_q] = 1'b1;
            if (m_RREADY[g_q] && (beat_cnt == len_q)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign s_ARID    = {g_q, id_q};
   assign s_ARADDR  = addr_q;
   assign s_ARLEN   = len_q;
   assign s_ARSIZE  = size_q;
   assign s_ARBURST = burst_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_axi_rd_router.sv
// Directed bench for axi_rd_router: default 4x2 map plus a 1-slave instance for DECERR.
module tb_axi_rd_router;
   import axi_ic_pkg::*;

   logic ACLK = 1'b0;
   logic ARESETn;
   always #5 ACLK = ~ACLK;

   int tests_run    = 0;
   int tests_failed = 0;

   // default instance: 4 masters, 2 slaves
   logic [15:0]  m_ARID;
   logic [127:0] m_ARADDR;
   logic [31:0]  m_ARLEN;
   logic [11:0]  m_ARSIZE;
   logic [7:0]   m_ARBURST;
   logic [3:0]   m_ARVALID, m_ARREADY, m_RVALID, m_RREADY;
   logic [3:0]   m_RID;
   logic [63:0]  m_RDATA;
   logic [1:0]   m_RRESP;
   logic         m_RLAST;
   logic [5:0]   s_ARID;
   logic [31:0]  s_ARADDR;
   logic [7:0]   s_ARLEN;
   logic [2:0]   s_ARSIZE;
   logic [1:0]   s_ARBURST;
   logic [1:0]   s_ARVALID, s_ARREADY;
   logic [11:0]  s_RID;
   logic [127:0] s_RDATA;
   logic [3:0]   s_RRESP;
   logic [1:0]   s_RLAST, s_RVALID, s_RREADY;
   rd_state_t    dbg_state;

   // single-slave instance: everything at 0x8000_0000 and above is unmapped
   logic [15:0]  e_m_ARID;
   logic [127:0] e_m_ARADDR;
   logic [31:0]  e_m_ARLEN;
   logic [11:0]  e_m_ARSIZE;
   logic [7:0]   e_m_ARBURST;
   logic [3:0]   e_m_ARVALID, e_m_ARREADY, e_m_RVALID, e_m_RREADY;
   logic [3:0]   e_m_RID;
   logic [63:0]  e_m_RDATA;
   logic [1:0]   e_m_RRESP;
   logic         e_m_RLAST;
   logic [5:0]   e_s_ARID;
   logic [31:0]  e_s_ARADDR;
   logic [7:0]   e_s_ARLEN;
   logic [2:0]   e_s_ARSIZE;
   logic [1:0]   e_s_ARBURST;
   logic         e_s_ARVALID, e_s_ARREADY;
   logic [5:0]   e_s_RID;
   logic [63:0]  e_s_RDATA;
   logic [1:0]   e_s_RRESP;
   logic         e_s_RLAST, e_s_RVALID, e_s_RREADY;
   rd_state_t    e_dbg_state;

   axi_rd_router dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .m_ARID(m_ARID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE),
      .m_ARBURST(m_ARBURST), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
      .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST),
      .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
      .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
      .s_ARBURST(s_ARBURST), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
      .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RLAST(s_RLAST),
      .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .dbg_state(dbg_state)
   );

   axi_rd_router #(
      .NUM_SLAVES(1), .SLAVE_BASE(32'h0), .SLAVE_MASK(32'h8000_0000)
   ) dut_err (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .m_ARID(e_m_ARID), .m_ARADDR(e_m_ARADDR), .m_ARLEN(e_m_ARLEN), .m_ARSIZE(e_m_ARSIZE),
      .m_ARBURST(e_m_ARBURST), .m_ARVALID(e_m_ARVALID), .m_ARREADY(e_m_ARREADY),
      .m_RID(e_m_RID), .m_RDATA(e_m_RDATA), .m_RRESP(e_m_RRESP), .m_RLAST(e_m_RLAST),
      .m_RVALID(e_m_RVALID), .m_RREADY(e_m_RREADY),
      .s_ARID(e_s_ARID), .s_ARADDR(e_s_ARADDR), .s_ARLEN(e_s_ARLEN), .s_ARSIZE(e_s_ARSIZE),
      .s_ARBURST(e_s_ARBURST), .s_ARVALID(e_s_ARVALID), .s_ARREADY(e_s_ARREADY),
      .s_RID(e_s_RID), .s_RDATA(e_s_RDATA), .s_RRESP(e_s_RRESP), .s_RLAST(e_s_RLAST),
      .s_RVALID(e_s_RVALID), .s_RREADY(e_s_RREADY), .dbg_state(e_dbg_state)
   );

   // ---------------- driver tasks ----------------
   task automatic init_inputs();
      m_ARID = '0; m_ARADDR = '0; m_ARLEN = '0; m_ARSIZE = '0; m_ARBURST = '0;
      m_ARVALID = '0; m_RREADY = '0;
      s_ARREADY = '0; s_RID = '0; s_RDATA = '0; s_RRESP = '0; s_RLAST = '0; s_RVALID = '0;
      e_m_ARID = '0; e_m_ARADDR = '0; e_m_ARLEN = '0; e_m_ARSIZE = '0; e_m_ARBURST = '0;
      e_m_ARVALID = '0; e_m_RREADY = '0;
      e_s_ARREADY = '0; e_s_RID = '0; e_s_RDATA = '0; e_s_RRESP = '0; e_s_RLAST = '0;
      e_s_RVALID = '0;
   endtask

   task automatic set_ar(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
      m_ARID[m*4 +: 4]     = id;
      m_ARADDR[m*32 +: 32] = addr;
      m_ARLEN[m*8 +: 8]    = len;
      m_ARSIZE[m*3 +: 3]   = 3'd3;
      m_ARBURST[m*2 +: 2]  = 2'b01;
   endtask

   // Called while the DUT sits in ADDR; returns at the negedge after the last beat.
   task automatic serve(input int s, input int len, input logic [5:0] rid,
                        input logic [3:0] mrdy);
      s_ARREADY    = '0;
      s_ARREADY[s] = 1'b1;
      @(negedge ACLK);
      s_ARREADY = '0;
      m_RREADY  = mrdy;
      for (int b = 0; b <= len; b++) begin
         s_RVALID            = '0;
         s_RVALID[s]         = 1'b1;
         s_RDATA[s*64 +: 64] = 64'(b);
         s_RID[s*6 +: 6]     = rid;
         s_RLAST             = '0;
         s_RLAST[s]          = (b == len);
         @(negedge ACLK);
      end
      s_RVALID = '0; s_RLAST = '0; m_RREADY = '0;
   endtask

   task automatic pulse_reset();
      @(negedge ACLK);
      ARESETn = 1'b0;
      @(negedge ACLK);
      ARESETn = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      ARESETn = 1'b0;
      init_inputs();
      repeat (2) @(negedge ACLK);
      #1;
      tests_run++;
      if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
      tests_run++;
      if ({m_ARREADY, m_RVALID, s_ARVALID, s_RREADY} !== 12'h0) begin
         tests_failed++; $display("FAIL reset_handshakes got=%h exp=000", {m_ARREADY, m_RVALID, s_ARVALID, s_RREADY});
      end
      tests_run++;
      if ({s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST} !== 51'h0) begin
         tests_failed++; $display("FAIL reset_payload got=%h exp=0", {s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST});
      end
      tests_run++;
      if ({e_m_RVALID, e_s_ARVALID} !== 5'h0) begin tests_failed++; $display("FAIL reset_err_inst got=%h exp=0", {e_m_RVALID, e_s_ARVALID}); end
      @(negedge ACLK);
      ARESETn = 1'b1;
   endtask

   task automatic test_m0_burst();
      logic [63:0] exp_data;
      @(negedge ACLK);
      set_ar(0, 4'h5, 32'h0000_0040, 8'd7);
      m_ARVALID = 4'b0001;
      s_RDATA[127:64] = '1;
      s_RRESP[3:2]    = 2'b10;
      #1;
      tests_run++;
      if (m_ARREADY !== 4'b0001) begin tests_failed++; $display("FAIL m0_arready got=%b exp=0001", m_ARREADY); end
      @(negedge ACLK);
      m_ARVALID = '0;
      #1;
      tests_run++;
      if (s_ARVALID !== 2'b01) begin tests_failed++; $display("FAIL m0_s_arvalid got=%b exp=01", s_ARVALID); end
      tests_run++;
      if (s_ARID !== 6'h05) begin tests_failed++; $display("FAIL m0_s_arid got=%h exp=05", s_ARID); end
      tests_run++;
      if ({s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST} !== {32'h40, 8'd7, 3'd3, 2'b01}) begin
         tests_failed++; $display("FAIL m0_s_payload got=%h/%0d/%0d/%0d exp=40/7/3/1", s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST);
      end
      tests_run++;
      if ({m_ARREADY, m_RVALID, s_RREADY} !== 10'h0) begin tests_failed++; $display("FAIL m0_addr_idle_hs got=%h exp=0", {m_ARREADY, m_RVALID, s_RREADY}); end
      @(negedge ACLK);
      #1;
      tests_run++;
      if (s_ARVALID !== 2'b01 || s_ARADDR !== 32'h40) begin
         tests_failed++; $display("FAIL m0_addr_hold got=%b/%h exp=01/00000040", s_ARVALID, s_ARADDR);
      end
      s_ARREADY = 2'b01;
      @(negedge ACLK);
      s_ARREADY = '0;
      m_RREADY  = 4'b0001;
      for (int b = 0; b < 8; b++) begin
         exp_data      = 64'hA5A5_0000_0000_0000 | 64'(b);
         s_RVALID      = 2'b01;
         s_RDATA[63:0] = exp_data;
         s_RID[5:0]    = 6'h05;
         s_RLAST       = {1'b0, b == 7};
         s_RRESP[1:0]  = RESP_OKAY;
         #1;
         tests_run++;
         if (m_RVALID !== 4'b0001 || s_RREADY !== 2'b01) begin
            tests_failed++; $display("FAIL m0_beat%0d_hs got=%b/%b exp=0001/01", b, m_RVALID, s_RREADY);
         end
         tests_run++;
         if (m_RDATA !== exp_data || m_RID !== 4'h5 || m_RRESP !== RESP_OKAY || m_RLAST !== (b == 7)) begin
            tests_failed++; $display("FAIL m0_beat%0d_payload got=%h/%h/%b/%b exp=%h/5/00/%b", b, m_RDATA, m_RID, m_RRESP, m_RLAST, exp_data, b == 7);
         end
         @(negedge ACLK);
      end
      s_RVALID = '0; s_RLAST = '0; m_RREADY = '0;
      s_RDATA = '0; s_RRESP = '0;
      #1;
      tests_run++;
      if (dbg_state !== ST_IDLE || m_RVALID !== 4'b0) begin
         tests_failed++; $display("FAIL m0_end got=%0d/%b exp=%0d/0000", dbg_state, m_RVALID, ST_IDLE);
      end
   endtask

   task automatic test_m1_single();
      @(negedge ACLK);
      set_ar(1, 4'hA, 32'h8000_0000, 8'd0);
      m_ARVALID = 4'b0010;
      #1;
      tests_run++;
      if (m_ARREADY !== 4'b0010) begin tests_failed++; $display("FAIL m1_arready got=%b exp=0010", m_ARREADY); end
      @(negedge ACLK);
      m_ARVALID = '0;
      #1;
      tests_run++;
      if (s_ARVALID !== 2'b10 || s_ARID !== 6'h1A) begin
         tests_failed++; $display("FAIL m1_s_ar got=%b/%h exp=10/1a", s_ARVALID, s_ARID);
      end
      s_ARREADY = 2'b10;
      @(negedge ACLK);
      s_ARREADY       = '0;
      s_RVALID        = 2'b10;
      s_RDATA[127:64] = 64'h0000_0000_DEAD_BEEF;
      s_RID[11:6]     = 6'h1A;
      s_RLAST         = 2'b10;
      m_RREADY        = 4'b0010;
      #1;
      tests_run++;
      if (m_RVALID !== 4'b0010 || s_RREADY !== 2'b10) begin
         tests_failed++; $display("FAIL m1_r_hs got=%b/%b exp=0010/10", m_RVALID, s_RREADY);
      end
      tests_run++;
      if (m_RDATA !== 64'hDEAD_BEEF || m_RLAST !== 1'b1 || m_RID !== 4'hA) begin
         tests_failed++; $display("FAIL m1_r_payload got=%h/%b/%h exp=deadbeef/1/a", m_RDATA, m_RLAST, m_RID);
      end
      @(negedge ACLK);
      s_RVALID = '0; s_RLAST = '0; m_RREADY = '0; s_RDATA = '0;
      #1;
      tests_run++;
      if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL m1_end got=%0d exp=%0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt;
      int         m;
      pulse_reset();
      for (int i = 0; i < 4; i++) set_ar(i, 4'(i + 8), 32'(i * 256), 8'd3);
      m_ARVALID = 4'b1111;
      for (int r = 0; r < 8; r++) begin
         m = r % 4;
         if (r == 4) m_ARVALID = 4'b1111;
         exp_gnt = 4'b0001 << m;
         #1;
         tests_run++;
         if (m_ARREADY !== exp_gnt) begin tests_failed++; $display("FAIL rr_grant%0d got=%b exp=%b", r, m_ARREADY, exp_gnt); end
         @(negedge ACLK);
         m_ARVALID[m] = 1'b0;
         #1;
         tests_run++;
         if (s_ARID !== {2'(m), 4'(m + 8)} || s_ARVALID !== 2'b01) begin
            tests_failed++; $display("FAIL rr_s_arid%0d got=%h/%b exp=%h/01", r, s_ARID, s_ARVALID, {2'(m), 4'(m + 8)});
         end
         serve(0, 3, {2'(m), 4'(m + 8)}, exp_gnt);
      end
      #1;
      tests_run++;
      if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL rr_end got=%0d exp=%0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_backpressure();
      int b = 0;
      @(negedge ACLK);
      set_ar(2, 4'h7, 32'h0000_0200, 8'd7);
      m_ARVALID = 4'b0100;
      #1;
      tests_run++;
      if (m_ARREADY !== 4'b0100) begin tests_failed++; $display("FAIL bp_arready got=%b exp=0100", m_ARREADY); end
      @(negedge ACLK);
      m_ARVALID = '0;
      s_ARREADY = 2'b01;
      @(negedge ACLK);
      s_ARREADY = '0;
      for (int c = 0; c < 40 && b < 8; c++) begin
         s_RVALID      = 2'b01;
         s_RDATA[63:0] = 64'h0000_BEEF_0000_0000 | 64'(b);
         s_RID[5:0]    = 6'h27;
         s_RLAST       = {1'b0, b == 7};
         m_RREADY      = c[0] ? 4'b0100 : 4'b0000;
         #1;
         tests_run++;
         if (m_RVALID !== 4'b0100 || m_RDATA !== (64'h0000_BEEF_0000_0000 | 64'(b)) || m_RID !== 4'h7) begin
            tests_failed++; $display("FAIL bp_beat%0d got=%b/%h/%h exp=0100/%h/7", b, m_RVALID, m_RDATA, m_RID, 64'h0000_BEEF_0000_0000 | 64'(b));
         end
         tests_run++;
         if (s_RREADY !== {1'b0, m_RREADY[2]}) begin
            tests_failed++; $display("FAIL bp_rready_mirror%0d got=%b exp=%b", c, s_RREADY, {1'b0, m_RREADY[2]});
         end
         if (m_RREADY[2]) b++;
         @(negedge ACLK);
      end
      s_RVALID = '0; s_RLAST = '0; m_RREADY = '0; s_RDATA = '0;
      #1;
      tests_run++;
      if (b !== 8 || dbg_state !== ST_IDLE) begin
         tests_failed++; $display("FAIL bp_complete got=%0d/%0d exp=8/%0d", b, dbg_state, ST_IDLE);
      end
   endtask

   task automatic test_decerr();
      int bad = 0;
      @(negedge ACLK);
      e_m_ARID[3:0]     = 4'h3;
      e_m_ARADDR[31:0]  = 32'h8000_0000;
      e_m_ARLEN[7:0]    = 8'd255;
      e_m_ARVALID       = 4'b0001;
      #1;
      tests_run++;
      if (e_m_ARREADY !== 4'b0001) begin tests_failed++; $display("FAIL err_arready got=%b exp=0001", e_m_ARREADY); end
      @(negedge ACLK);
      e_m_ARVALID = '0;
      // stall a few cycles: the first beat must be held, not counted
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (e_m_RVALID !== 4'b0001 || e_m_RLAST !== 1'b0) begin
            tests_failed++; $display("FAIL err_stall%0d got=%b/%b exp=0001/0", c, e_m_RVALID, e_m_RLAST);
         end
         @(negedge ACLK);
      end
      e_m_RREADY = 4'b0001;
      for (int b = 0; b < 256; b++) begin
         #1;
         tests_run++;
         if (e_m_RVALID !== 4'b0001 || e_m_RDATA !== 64'h0 || e_m_RRESP !== RESP_DECERR ||
             e_m_RID !== 4'h3 || e_m_RLAST !== (b == 255) || e_s_ARVALID !== 1'b0) begin
            tests_failed++;
            if (bad < 4) $display("FAIL err_beat%0d got=%b/%h/%b/%h/%b/%b exp=0001/0/11/3/%b/0", b, e_m_RVALID, e_m_RDATA, e_m_RRESP, e_m_RID, e_m_RLAST, e_s_ARVALID, b == 255);
            bad++;
         end
         @(negedge ACLK);
      end
      e_m_RREADY = '0;
      #1;
      tests_run++;
      if (e_dbg_state !== ST_IDLE || e_m_RVALID !== 4'b0) begin
         tests_failed++; $display("FAIL err_end got=%0d/%b exp=%0d/0000", e_dbg_state, e_m_RVALID, ST_IDLE);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge ACLK);
      set_ar(0, 4'h1, 32'h0000_0080, 8'd7);
      m_ARVALID = 4'b0001;
      @(negedge ACLK);
      m_ARVALID = '0;
      s_ARREADY = 2'b01;
      @(negedge ACLK);
      s_ARREADY = '0;
      m_RREADY  = 4'b0001;
      for (int b = 0; b < 2; b++) begin
         s_RVALID = 2'b01; s_RID[5:0] = 6'h01; s_RDATA[63:0] = 64'(b); s_RLAST = 2'b00;
         @(negedge ACLK);
      end
      s_RVALID = 2'b01; s_RDATA[63:0] = 64'd2;
      #1;
      tests_run++;
      if (m_RVALID !== 4'b0001) begin tests_failed++; $display("FAIL rst_mid_pre got=%b exp=0001", m_RVALID); end
      ARESETn = 1'b0;
      #1;
      tests_run++;
      if ({m_ARREADY, m_RVALID, s_ARVALID, s_RREADY} !== 12'h0 || dbg_state !== ST_IDLE) begin
         tests_failed++; $display("FAIL rst_mid_abort got=%h/%0d exp=000/%0d", {m_ARREADY, m_RVALID, s_ARVALID, s_RREADY}, dbg_state, ST_IDLE);
      end
      @(negedge ACLK);
      s_RVALID = '0; m_RREADY = '0;
      ARESETn = 1'b1;
      set_ar(2, 4'h2, 32'h0000_0300, 8'd0);
      m_ARVALID = 4'b0101;
      #1;
      tests_run++;
      if (m_ARREADY !== 4'b0001) begin tests_failed++; $display("FAIL rst_mid_first_grant got=%b exp=0001", m_ARREADY); end
      @(negedge ACLK);
      m_ARVALID = '0;
   endtask

   initial begin
      test_reset();
      test_m0_burst();
      test_m1_single();
      test_round_robin();
      test_backpressure();
      test_decerr();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
